// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/TRAP control, next-PC target selection
// and a circular return-address stack that overwrites its oldest entry on overflow.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic [WIDTH-1:0] ImmOp,
    input  logic [WIDTH-1:0] rs1,
    input  logic             push,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             fetch_valid,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [1:0]       dbg_state
);

    // Handshake: PC_OUT is offered while fetch_valid=1 and is consumed on a rising
    // edge where fetch_ready=1 and stall=0; until then PC_OUT and all state hold.

    localparam int unsigned      PW      = $clog2(RAS_DEPTH);
    localparam int unsigned      CW      = PW + 1;
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               misalign_q, misalign_d;
    logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
    logic [WIDTH-1:0]   ras_d [RAS_DEPTH];
    logic [PW-1:0]      top_q, top_d;
    logic [CW-1:0]      count_q, count_d;

    logic [WIDTH-1:0]   pc_inc;
    logic [WIDTH-1:0]   jr_sum;
    logic [WIDTH-1:0]   target;
    logic [PW-1:0]      top_inc;
    logic [PW-1:0]      top_dec;
    logic               advance;
    logic               do_pop;

    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == DEPTH_C);

    always_comb begin
        pc_inc  = pc_q + INC_W;
        jr_sum  = rs1 + ImmOp;
        top_inc = top_q + PW'(1);
        top_dec = top_q - PW'(1);
        do_pop  = (pc_sel == 2'b11) && !ras_empty;
        advance = (state_q == S_RUN) && fetch_valid_q && fetch_ready && !stall;

        case (pc_sel)
            2'b00:   target = pc_inc;
            2'b01:   target = pc_q + ImmOp;
            2'b10:   target = {jr_sum[WIDTH-1:1], 1'b0};
            default: target = ras_empty ? pc_inc : ras_q[top_q];
        endcase

        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        misalign_d    = misalign_q;
        ras_d         = ras_q;
        top_d         = top_q;
        count_d       = count_q;

        case (state_q)
            S_BOOT: begin
                state_d       = S_RUN;
                fetch_valid_d = 1'b1;
            end
            S_RUN: begin
                if (advance) begin
                    if (target[1:0] != 2'b00) begin
                        state_d       = S_TRAP;
                        fetch_valid_d = 1'b0;
                        misalign_d    = 1'b1;
                    end else begin
                        pc_d = target;
                        // Call and return together replace the top entry in place.
                        if (push && do_pop) begin
                            ras_d[top_q] = pc_inc;
                        end else if (push) begin
                            top_d          = top_inc;
                            ras_d[top_inc] = pc_inc;
                            if (count_q != DEPTH_C) count_d = count_q + CW'(1);
                        end else if (do_pop) begin
                            top_d   = top_dec;
                            count_d = count_q - CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d       = S_TRAP;
                fetch_valid_d = 1'b0;
                misalign_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            top_q         <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            top_q         <= top_d;
            count_q       <= count_d;
            ras_q         <= ras_d;
        end
    end

    assign PC_OUT      = pc_q;
    assign pc_plus_inc = pc_inc;
    assign fetch_valid = fetch_valid_q;
    assign misalign    = misalign_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: PC and operand width in bits, minimum 8.
REQ-002 The block SHALL take parameter RESET_VECTOR, default 0: the PC value loaded on reset.
REQ-003 The block SHALL take parameter INC, default 4: the sequential PC increment.
REQ-004 The block SHALL take parameter RAS_DEPTH, default 4: the number of return-address stack entries, power of two, minimum 2.
REQ-005 The block SHALL provide port clk, input, width 1: the single clock, rising-edge active.
REQ-006 The block SHALL provide port rst, input, width 1: the reset, asynchronous and active-low.
REQ-007 The block SHALL provide port stall, input, width 1: holds the PC when 1.
REQ-008 The block SHALL provide port pc_sel, input, width 2: target select; 00 = sequential, 01 = branch-relative, 10 = jump-register, 11 = return.
REQ-009 The block SHALL provide port ImmOp, input, width WIDTH: the immediate offset.
REQ-010 The block SHALL provide port rs1, input, width WIDTH: the register base for jump-register.
REQ-011 The block SHALL provide port push, input, width 1: the call indication; pushes the return address.
REQ-012 The block SHALL provide port fetch_ready, input, width 1: the instruction memory accepts PC_OUT.
REQ-013 The block SHALL provide port PC_OUT, output, width WIDTH: the current PC.
REQ-014 The block SHALL provide port pc_plus_inc, output, width WIDTH: PC_OUT + INC (link value).
REQ-015 The block SHALL provide port fetch_valid, output, width 1: PC_OUT is a valid fetch request.
REQ-016 The block SHALL provide port misalign, output, width 1: a sticky trap flag for a misaligned target.
REQ-017 The block SHALL provide ports ras_empty and ras_full, output, width 1 each: the stack status.

Function
REQ-018 The block SHALL implement the state machine BOOT -> RUN -> TRAP; TRAP SHALL exit only on reset.
REQ-019 In BOOT, the block SHALL drive fetch_valid=0 and PC_OUT=RESET_VECTOR, and SHALL move to RUN unconditionally on the next clock edge.
REQ-020 In RUN, the block SHALL drive fetch_valid=1; "advance" SHALL be defined as RUN && fetch_valid && fetch_ready && !stall.
REQ-021 The PC SHALL update only on advance; otherwise the PC, the stack and the flags SHALL hold.
REQ-022 The next-PC target SHALL be selected by pc_sel as follows:
- 00: PC+INC.
- 01: PC+ImmOp.
- 10: (rs1+ImmOp) with bit 0 cleared.
- 11: the RAS top entry, or PC+INC if ras_empty.
REQ-023 All additions SHALL be modulo 2^WIDTH, with silent wrap-around and no carry out.
REQ-024 If the selected target has bits [1:0] != 00 on advance, the PC SHALL hold, misalign SHALL be set to 1, the state SHALL go to TRAP and the stack SHALL not change.
REQ-025 In TRAP, the block SHALL drive fetch_valid=0 and misalign=1, and all inputs SHALL be ignored.
REQ-026 On advance with push=1, the block SHALL push PC+INC of the current PC onto the RAS.
REQ-027 On advance with pc_sel=11 and !ras_empty, the block SHALL pop the top entry.
REQ-028 Simultaneous pop and push SHALL use the old top entry as the target, write the new value into the top slot, and leave the count unchanged.
REQ-029 A push while full SHALL overwrite the oldest entry (circular), leave the count at RAS_DEPTH and keep ras_full=1.
REQ-030 A pop while empty SHALL not underflow: the count SHALL stay 0 and the target SHALL be sequential.
REQ-031 The RAS count SHALL range over 0..RAS_DEPTH; ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both combinational from registered state.
REQ-032 PC_OUT SHALL be registered, and the new PC SHALL be visible one cycle after the advancing edge.

Reset
REQ-033 On assertion of rst=0, the block SHALL immediately and asynchronously set the state to BOOT, PC_OUT=RESET_VECTOR, fetch_valid=0, misalign=0, RAS count=0, ras_empty=1 and ras_full=0.
REQ-034 Reset asserted mid-operation, including in TRAP or while stalled, SHALL discard all stack contents and pending state.
REQ-035 The first fetch_valid=1 SHALL occur exactly one cycle after reset deassertion, with PC_OUT=RESET_VECTOR.

Verification
REQ-036 The bench SHALL cover WIDTH=32, RESET_VECTOR=0x100: release reset, pc_sel=00, fetch_ready=1 for 3 edges -> fetch_valid rises 1 cycle after release; PC_OUT sequence 0x100, 0x104, 0x108, 0x10C.
REQ-037 The bench SHALL cover PC=0x200, pc_sel=01, ImmOp=0xFFFFFFF8 -> PC_OUT=0x1F8; then stall=1 for 2 cycles -> PC_OUT holds 0x1F8; fetch_ready=0 -> holds.
REQ-038 The bench SHALL cover PC=0x300, push=1, pc_sel=10, rs1=0x1000, ImmOp=1 -> PC_OUT=0x1000 and RAS top=0x304; later pc_sel=11 -> PC_OUT=0x304, ras_empty=1.
REQ-039 The bench SHALL cover 5 pushes with RAS_DEPTH=4 -> ras_full=1 and 4 pops returning the last 4 addresses in LIFO order; a 5th pop -> sequential PC, count stays 0.
REQ-040 The bench SHALL cover pc_sel=01 with ImmOp=0x2 -> misalign=1, fetch_valid=0, PC unchanged and further inputs ignored; then rst=0 mid-cycle -> misalign=0 and PC=RESET_VECTOR asynchronously.
REQ-041 The bench SHALL cover PC=0xFFFFFFFC with pc_sel=00 -> PC_OUT wraps to 0x00000000 with no trap.
